// File: rtl/funnel_stream_sequencer_pkg.sv
// Shared definitions for the funnel stream sequencer: default widths,
// FSM state encoding and a small range-check helper.
package funnel_stream_sequencer_pkg;

  localparam int DEF_W  = 10;
  localparam int DEF_AW = 4;
  localparam int DEF_CW = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FIRST = ST_FIRST,
    RUN   = ST_RUN,
    FLUSH = ST_FLUSH
  } state_e;

  // A shift amount is usable only if it is strictly below the word width.
  function automatic logic amt_in_range(input logic [31:0] amt_val, input int width);
    return (amt_val < 32'(width));
  endfunction

endpackage

// File: rtl/funnel_stream_sequencer_funnel_core.sv
// Combinational right funnel shifter: y = low W bits of ({hi,lo} >> amt).
module funnel_core
  import funnel_stream_sequencer_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic [W-1:0]  hi,
  input  logic [W-1:0]  lo,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  y
);

  // Concatenate, shift right, keep the low word.
  always_comb begin
    y = W'({hi, lo} >> amt);
  end

endmodule

// File: rtl/funnel_stream_sequencer.sv
// Funnel stream sequencer: strips `amt` leading bits from a packet of words by
// funnelling each next word (hi) with the current word (lo). One word is held
// in `prev`; the last word of a packet is flushed against zero.
module funnel_stream_sequencer
  import funnel_stream_sequencer_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [AW-1:0] cfg_amt,
  output logic          cfg_ready,
  output logic          cfg_err,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [AW-1:0] amt,
  output logic          busy,
  output logic [CW-1:0] pkt_count
);

  localparam logic [W-1:0]  WORD_ZERO = {W{1'b0}};
  localparam logic [AW-1:0] AMT_ZERO  = {AW{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] amt_q, amt_d;
  logic [W-1:0]  prev_q, prev_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          cfg_err_q, cfg_err_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;

  logic          slot_free_s;
  logic          cfg_ready_s;
  logic          in_ready_s;
  logic          in_acc_s;
  logic          cfg_acc_s;
  logic          cfg_ok_s;
  logic [W-1:0]  core_hi_s;
  logic [W-1:0]  core_y_s;

  // Handshake qualifiers derived from the current state and output slot.
  always_comb begin
    slot_free_s = (~out_valid_q) | out_ready;
    cfg_ready_s = (state_q == IDLE) | (state_q == FIRST);
    in_ready_s  = (state_q == FIRST) | ((state_q == RUN) & slot_free_s);
    in_acc_s    = in_valid & in_ready_s;
    cfg_acc_s   = cfg_valid & cfg_ready_s;
    cfg_ok_s    = amt_in_range(32'(cfg_amt), W);
  end

  // Funnel hi operand: the incoming word while streaming, zero when flushing.
  always_comb begin
    if (state_q == FLUSH) begin
      core_hi_s = WORD_ZERO;
    end else begin
      core_hi_s = in_data;
    end
  end

  funnel_core #(
    .W  (W),
    .AW (AW)
  ) u_funnel_core (
    .hi  (core_hi_s),
    .lo  (prev_q),
    .amt (amt_q),
    .y   (core_y_s)
  );

  // Next-state, prev, output register and packet counter logic.
  always_comb begin
    state_d     = state_q;
    amt_d       = amt_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    cfg_err_d   = 1'b0;
    pkt_count_d = pkt_count_q;

    // A drained slot empties unless something below reloads it.
    if (slot_free_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Config is only seen in IDLE/FIRST, so amt never moves mid-packet.
    if (cfg_acc_s) begin
      if (cfg_ok_s) begin
        amt_d = cfg_amt;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cfg_acc_s & cfg_ok_s) begin
          state_d = FIRST;
        end else begin
          state_d = IDLE;
        end
      end
      FIRST: begin
        if (in_acc_s) begin
          prev_d = in_data;
          if (in_last) begin
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = FIRST;
        end
      end
      RUN: begin
        if (in_acc_s) begin
          out_data_d  = core_y_s;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          prev_d      = in_data;
          if (in_last) begin
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (slot_free_s) begin
          out_data_d  = core_y_s;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          pkt_count_d = pkt_count_q + CNT_ONE;
          state_d     = FIRST;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      amt_q       <= AMT_ZERO;
      prev_q      <= WORD_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= WORD_ZERO;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      pkt_count_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      amt_q       <= amt_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Port drive: handshake readies are combinational, everything else registered.
  always_comb begin
    cfg_ready = cfg_ready_s;
    in_ready  = in_ready_s;
    cfg_err   = cfg_err_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
    amt       = amt_q;
    busy      = (state_q == RUN) | (state_q == FLUSH);
    pkt_count = pkt_count_q;
  end

endmodule
